// File: rtl/uni_shift_reg_p.sv
// uni_shift_reg_p: parametrised universal shift register.
// Supports hold, logical shifts, rotates, arithmetic shift right and parallel
// load, all by a multi-bit amount. A self-timed serialiser mode streams din
// out LSB first on sout, with a busy (ready=0) / done handshake.
module uni_shift_reg_p #(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] din,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             sout_vld,
    output logic             ready,
    output logic             done
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_SER  = 3'b111;

    localparam logic [AW-1:0] LAST_CNT  = AW'(WIDTH - 1);
    localparam logic [AW:0]   WIDTH_EXT = (AW + 1)'(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state;
    state_t               next_state;
    logic [AW-1:0]        cnt;
    logic [AW-1:0]        cnt_nxt;
    logic [WIDTH-1:0]     q_nxt;
    logic                 sout_nxt;
    logic                 vld_nxt;
    logic                 accept;
    logic [AW-1:0]        amt_eff;
    logic [AW-1:0]        shl_idx;
    logic                 fill;
    logic [2*WIDTH-1:0]   wide;

    assign accept = en & ready;

    // Fold amounts beyond WIDTH-1 back into range (only reachable for non-power-of-2 widths).
    always_comb begin
        if ({1'b0, amt} >= WIDTH_EXT) begin
            amt_eff = amt - AW'(WIDTH);
        end else begin
            amt_eff = amt;
        end
        shl_idx = LAST_CNT - amt_eff + AW'(1);
    end

    // State register for the serialiser sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: SER launches a WIDTH-edge shift burst followed by one DONE cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept && (mode == MODE_SER)) next_state = SHIFT;
            SHIFT:   if (cnt == LAST_CNT) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Handshake outputs decoded directly from the state.
    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    // Datapath next values: serial shifting while busy, otherwise the accepted command.
    always_comb begin
        q_nxt    = q;
        sout_nxt = sout;
        vld_nxt  = 1'b0;
        cnt_nxt  = cnt;
        wide     = '0;
        fill     = sin;
        if (state == SHIFT) begin
            q_nxt    = {sin, q[WIDTH-1:1]};
            sout_nxt = q[0];
            vld_nxt  = 1'b1;
            cnt_nxt  = cnt + AW'(1);
        end else if (accept) begin
            case (mode)
                MODE_SHR, MODE_ASR: begin
                    if (amt_eff != '0) begin
                        fill     = (mode == MODE_ASR) ? q[WIDTH-1] : sin;
                        wide     = {{WIDTH{fill}}, q} >> amt_eff;
                        q_nxt    = wide[WIDTH-1:0];
                        sout_nxt = q[amt_eff - AW'(1)];
                    end
                end
                MODE_SHL: begin
                    if (amt_eff != '0) begin
                        wide     = {q, {WIDTH{sin}}} << amt_eff;
                        q_nxt    = wide[2*WIDTH-1:WIDTH];
                        sout_nxt = q[shl_idx];
                    end
                end
                MODE_LOAD: q_nxt = din;
                MODE_ROR: begin
                    wide  = {q, q} >> amt_eff;
                    q_nxt = wide[WIDTH-1:0];
                end
                MODE_ROL: begin
                    wide  = {q, q} << amt_eff;
                    q_nxt = wide[2*WIDTH-1:WIDTH];
                end
                MODE_SER: begin
                    q_nxt   = din;
                    cnt_nxt = '0;
                end
                MODE_HOLD: q_nxt = q;
                default:   q_nxt = q;
            endcase
        end
    end

    // Datapath registers; reset clears everything including an in-flight serialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            sout     <= 1'b0;
            sout_vld <= 1'b0;
            cnt      <= '0;
        end else begin
            q        <= q_nxt;
            sout     <= sout_nxt;
            sout_vld <= vld_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_uni_shift_reg_p.sv
// Testbench for uni_shift_reg_p (WIDTH=8): directed and randomised commands
// checked against a bit-at-a-time behavioural model of the register.
module tb_uni_shift_reg_p;

    localparam int W  = 8;
    localparam int AW = $clog2(W);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [2:0]    mode;
    logic [AW-1:0] amt;
    logic [W-1:0]  din;
    logic          sin;
    logic [W-1:0]  q;
    logic          sout;
    logic          sout_vld;
    logic          ready;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] m_q;
    logic         m_sout;

    uni_shift_reg_p #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .amt(amt),
        .din(din), .sin(sin), .q(q), .sout(sout), .sout_vld(sout_vld),
        .ready(ready), .done(done)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Behavioural model: every shift/rotate is performed one bit at a time, amt times.
    function automatic void model_cmd(input logic [2:0] m, input int a,
                                      input logic [W-1:0] d, input logic s);
        int n;
        logic [W-1:0] t;
        logic so;
        n  = a % W;
        t  = m_q;
        so = m_sout;
        case (m)
            3'd1: for (int i = 0; i < n; i++) begin so = t[0];   t = {s, t[W-1:1]}; end
            3'd2: for (int i = 0; i < n; i++) begin so = t[W-1]; t = {t[W-2:0], s}; end
            3'd3: t = d;
            3'd4: for (int i = 0; i < n; i++) t = {t[0], t[W-1:1]};
            3'd5: for (int i = 0; i < n; i++) t = {t[W-2:0], t[W-1]};
            3'd6: for (int i = 0; i < n; i++) begin so = t[0];   t = {t[W-1], t[W-1:1]}; end
            default: ;
        endcase
        m_q    = t;
        m_sout = so;
    endfunction

    // Present one command for a single accepting edge, then sample #1 after it.
    task automatic issue(input logic [2:0] m, input int a, input logic [W-1:0] d, input logic s);
        @(negedge clk);
        en   = 1'b1;
        mode = m;
        amt  = AW'(a);
        din  = d;
        sin  = s;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic test_reset;
        issue(3'd3, 0, 8'hA5, 1'b0);
        issue(3'd1, 3, 8'h00, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (q !== 8'h00)     begin n_fail++; $display("[TB] FAIL reset_q got %h want 00", q); end
        n_checks++; if (ready !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset_ready got %b want 1", ready); end
        n_checks++; if (done !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_done got %b want 0", done); end
        n_checks++; if (sout !== 1'b0)   begin n_fail++; $display("[TB] FAIL reset_sout got %b want 0", sout); end
        n_checks++; if (sout_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_vld got %b want 0", sout_vld); end
        @(negedge clk);
        rst_n  = 1'b1;
        m_q    = '0;
        m_sout = 1'b0;
    endtask

    task automatic test_directed;
        issue(3'd3, 0, 8'hA5, 1'b0); model_cmd(3'd3, 0, 8'hA5, 1'b0);
        issue(3'd1, 3, 8'h00, 1'b1); model_cmd(3'd1, 3, 8'h00, 1'b1);
        n_checks++; if (q !== 8'hF4)  begin n_fail++; $display("[TB] FAIL shr_q got %h want f4", q); end
        n_checks++; if (sout !== 1'b1) begin n_fail++; $display("[TB] FAIL shr_sout got %b want 1", sout); end
        issue(3'd3, 0, 8'h80, 1'b0); model_cmd(3'd3, 0, 8'h80, 1'b0);
        issue(3'd6, 2, 8'h00, 1'b1); model_cmd(3'd6, 2, 8'h00, 1'b1);
        n_checks++; if (q !== 8'hE0)  begin n_fail++; $display("[TB] FAIL asr_q got %h want e0", q); end
        n_checks++; if (sout !== 1'b0) begin n_fail++; $display("[TB] FAIL asr_sout got %b want 0", sout); end
        issue(3'd3, 0, 8'h81, 1'b0); model_cmd(3'd3, 0, 8'h81, 1'b0);
        issue(3'd5, 1, 8'h00, 1'b0); model_cmd(3'd5, 1, 8'h00, 1'b0);
        n_checks++; if (q !== 8'h03)  begin n_fail++; $display("[TB] FAIL rol_q got %h want 03", q); end
        issue(3'd4, 4, 8'h00, 1'b0); model_cmd(3'd4, 4, 8'h00, 1'b0);
        n_checks++; if (q !== 8'h30)  begin n_fail++; $display("[TB] FAIL ror_q got %h want 30", q); end
        issue(3'd2, 0, 8'h00, 1'b1); model_cmd(3'd2, 0, 8'h00, 1'b1);
        n_checks++; if (q !== 8'h30)  begin n_fail++; $display("[TB] FAIL shl0_q got %h want 30", q); end
        n_checks++; if (sout !== 1'b0) begin n_fail++; $display("[TB] FAIL shl0_sout got %b want 0", sout); end
        n_checks++; if (sout_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL cmd_vld got %b want 0", sout_vld); end
    endtask

    task automatic test_random_ops;
        logic [2:0] m;
        int a;
        logic [W-1:0] d;
        logic s;
        for (int it = 0; it < 60; it++) begin
            m = 3'($urandom_range(0, 6));
            a = int'($urandom_range(0, W - 1));
            d = W'($urandom);
            s = 1'($urandom);
            issue(m, a, d, s);
            model_cmd(m, a, d, s);
            n_checks++; if (q !== m_q) begin n_fail++; $display("[TB] FAIL rand_q mode %0d amt %0d got %h want %h", m, a, q, m_q); end
            n_checks++; if (sout !== m_sout) begin n_fail++; $display("[TB] FAIL rand_sout mode %0d amt %0d got %b want %b", m, a, sout, m_sout); end
            n_checks++; if (ready !== 1'b1 || done !== 1'b0 || sout_vld !== 1'b0) begin
                n_fail++; $display("[TB] FAIL rand_flags ready %b done %b vld %b want 1 0 0", ready, done, sout_vld);
            end
        end
    endtask

    // Full serialisation; optionally tries a LOAD 0xFF while busy, which must be ignored.
    task automatic test_ser(input logic [W-1:0] d, input logic s, input bit inject);
        logic [W-1:0] exp_q;
        issue(3'd7, 0, d, s);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ser_accept_ready got %b want 0", ready); end
        n_checks++; if (q !== d)        begin n_fail++; $display("[TB] FAIL ser_accept_q got %h want %h", q, d); end
        exp_q = d;
        for (int k = 1; k <= W; k++) begin
            if (inject && k == 3) begin
                @(negedge clk);
                en = 1'b1; mode = 3'd3; din = 8'hFF;
            end
            @(posedge clk);
            #1;
            en = 1'b0;
            exp_q = {s, exp_q[W-1:1]};
            n_checks++; if (sout !== d[k-1]) begin n_fail++; $display("[TB] FAIL ser_bit%0d got %b want %b", k, sout, d[k-1]); end
            n_checks++; if (sout_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL ser_vld%0d got %b want 1", k, sout_vld); end
            n_checks++; if (done !== (k == W)) begin n_fail++; $display("[TB] FAIL ser_done%0d got %b want %b", k, done, (k == W)); end
            n_checks++; if (ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ser_busy%0d got %b want 0", k, ready); end
        end
        @(posedge clk);
        #1;
        n_checks++; if (ready !== 1'b1) begin n_fail++; $display("[TB] FAIL ser_end_ready got %b want 1", ready); end
        n_checks++; if (done !== 1'b0 || sout_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL ser_end_flags done %b vld %b want 0 0", done, sout_vld); end
        n_checks++; if (q !== exp_q) begin n_fail++; $display("[TB] FAIL ser_end_q got %h want %h", q, exp_q); end
        m_q    = exp_q;
        m_sout = d[W-1];
    endtask

    task automatic test_reset_mid_ser;
        issue(3'd7, 0, 8'h5A, 1'b1);
        repeat (4) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        n_checks++; if (q !== 8'h00) begin n_fail++; $display("[TB] FAIL abort_q got %h want 00", q); end
        n_checks++; if (ready !== 1'b1 || done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_flags ready %b done %b want 1 0", ready, done); end
        n_checks++; if (sout_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_vld got %b want 0", sout_vld); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_nodone cycle %0d got %b want 0", i, done); end
        end
        @(negedge clk);
        rst_n  = 1'b1;
        m_q    = '0;
        m_sout = 1'b0;
        test_ser(W'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic test_back_to_back;
        int cycles;
        int dones;
        logic [W-1:0] d;
        logic s;
        for (int r = 0; r < 3; r++) begin
            d = W'($urandom);
            s = 1'($urandom);
            issue(3'd7, 0, d, s);
            cycles = 0;
            dones  = 0;
            while (ready !== 1'b1 && cycles < 3 * W) begin
                @(posedge clk);
                #1;
                cycles++;
                if (done === 1'b1) dones++;
            end
            n_checks++; if (cycles !== W + 1) begin n_fail++; $display("[TB] FAIL b2b_busy_cycles got %0d want %0d", cycles, W + 1); end
            n_checks++; if (dones !== 1) begin n_fail++; $display("[TB] FAIL b2b_done_pulses got %0d want 1", dones); end
            m_q    = {W{s}};
            m_sout = d[W-1];
            n_checks++; if (q !== m_q) begin n_fail++; $display("[TB] FAIL b2b_q got %h want %h", q, m_q); end
            d = W'($urandom);
            issue(3'd3, 0, d, 1'b0);
            model_cmd(3'd3, 0, d, 1'b0);
            n_checks++; if (q !== m_q) begin n_fail++; $display("[TB] FAIL b2b_load got %h want %h", q, m_q); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 3'd0;
        amt   = '0;
        din   = '0;
        sin   = 1'b0;
        m_q    = '0;
        m_sout = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] starting");
        test_reset;
        test_directed;
        test_random_ops;
        test_ser(8'hB4, 1'b0, 1'b0);
        test_ser(8'hB4, 1'b0, 1'b1);
        test_ser(W'($urandom), 1'b1, 1'b1);
        test_reset_mid_ser;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
